// File: rtl/data_mem_pkg.sv
// Shared encodings and helpers for the byte-addressed load/store data memory.
// Covers the access-size and FSM-state encodings, the alignment rule and load lane extraction.
package data_mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Reserved size is always rejected; halves need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lane);
    logic err;
    case (sz)
      SIZE_BYTE: err = 1'b0;
      SIZE_HALF: err = lane[0];
      SIZE_WORD: err = (lane != 2'b00);
      default:   err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  sz,
                                               input logic [1:0]  lane,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (sz)
      SIZE_BYTE: r = {{24{~uns & b[7]}}, b};
      SIZE_HALF: r = {{16{~uns & h[15]}}, h};
      SIZE_WORD: r = word;
      default:   r = 32'h0000_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_mem_resp_pipe.sv
// Fixed-depth delay line for load/store responses; reset flushes everything in flight.
// The output is taken straight from the last stage, so response timing never depends on logic.
module data_mem_resp_pipe #(
  parameter int STAGES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        err_i,
  input  logic [31:0] data_i,
  output logic        valid_o,
  output logic        err_o,
  output logic [31:0] data_o
);

  logic [STAGES-1:0]       valid_q;
  logic [STAGES-1:0]       err_q;
  logic [STAGES-1:0][31:0] data_q;

  // Shift register; stage 0 captures the response at the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      err_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q[0] <= valid_i;
      err_q[0]   <= err_i;
      data_q[0]  <= data_i;
      for (int i = 1; i < STAGES; i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[STAGES-1];
  assign err_o   = err_q[STAGES-1];
  assign data_o  = data_q[STAGES-1];

endmodule

// File: rtl/data_mem_pipelined.sv
// Single-port byte-addressed data memory with sized, extended loads and fixed-latency responses.
// After reset an optional walk zeroes every word before requests are accepted.
module data_mem_pipelined
  import data_mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 22,
  parameter int DEPTH_WORDS    = 1024,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqWrite,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [1:0]            size,
  input  logic                  unsignedLoad,
  input  logic [31:0]           dataIn,
  output logic                  respValid,
  output logic                  respError,
  output logic [31:0]           dataOut,
  output logic                  busy
);

  localparam int     IDX_W     = $clog2(DEPTH_WORDS);
  localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  logic [31:0]      mem_q [DEPTH_WORDS];
  state_e           state_q, state_d;
  logic [IDX_W-1:0] clear_idx_q, clear_idx_d;
  logic             ready_q, busy_q;

  logic             accept_s;
  logic [1:0]       lane_s;
  logic [IDX_W-1:0] word_idx_s;
  logic             err_s;
  logic [31:0]      rd_word_s;
  logic             we_s;
  logic [IDX_W-1:0] wr_idx_s;
  logic [31:0]      wr_data_s;
  logic [3:0]       wr_mask_s;
  logic             resp_valid_s;
  logic             resp_err_s;
  logic [31:0]      resp_data_s;

  if (ADDR_WIDTH > IDX_W + 2) begin : g_addr_hi
    logic unused_addr_hi_s;
    assign unused_addr_hi_s = ^address[ADDR_WIDTH-1:IDX_W+2];
  end

  // Clear-walk sequencing: one word per cycle, leaving CLEAR after the last index.
  always_comb begin
    state_d     = state_q;
    clear_idx_d = clear_idx_q;
    case (state_q)
      ST_CLEAR: begin
        if (clear_idx_q == IDX_W'(DEPTH_WORDS - 1)) begin
          state_d     = ST_READY;
          clear_idx_d = '0;
        end else begin
          clear_idx_d = clear_idx_q + IDX_W'(1);
        end
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = RST_STATE;
    endcase
  end

  // State and handshake flags; ready/busy are registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RST_STATE;
      clear_idx_q <= '0;
      ready_q     <= 1'b0;
      busy_q      <= (CLEAR_ON_RESET != 0);
    end else begin
      state_q     <= state_d;
      clear_idx_q <= clear_idx_d;
      ready_q     <= (state_d == ST_READY);
      busy_q      <= (state_d == ST_CLEAR);
    end
  end

  assign accept_s   = reqValid && ready_q;
  assign lane_s     = address[1:0];
  assign word_idx_s = address[IDX_W+1:2];
  assign err_s      = is_misaligned(size, lane_s);
  assign rd_word_s  = mem_q[word_idx_s];

  // Write port shared by the clear walk and accepted, well-formed stores.
  always_comb begin
    we_s      = 1'b0;
    wr_idx_s  = word_idx_s;
    wr_data_s = 32'h0000_0000;
    wr_mask_s = 4'b0000;
    if (state_q == ST_CLEAR) begin
      we_s      = 1'b1;
      wr_idx_s  = clear_idx_q;
      wr_mask_s = 4'b1111;
    end else if (accept_s && reqWrite && !err_s) begin
      we_s = 1'b1;
      case (size)
        SIZE_BYTE: begin
          wr_data_s = {4{dataIn[7:0]}};
          wr_mask_s = 4'b0001 << lane_s;
        end
        SIZE_HALF: begin
          wr_data_s = {2{dataIn[15:0]}};
          wr_mask_s = lane_s[1] ? 4'b1100 : 4'b0011;
        end
        SIZE_WORD: begin
          wr_data_s = dataIn;
          wr_mask_s = 4'b1111;
        end
        default: we_s = 1'b0;
      endcase
    end else begin
      we_s = 1'b0;
    end
  end

  // Storage array with per-byte-lane enables; contents are not reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask_s[b]) begin
          mem_q[wr_idx_s][b*8 +: 8] <= wr_data_s[b*8 +: 8];
        end
      end
    end
  end

  assign resp_valid_s = accept_s;
  assign resp_err_s   = accept_s && err_s;
  assign resp_data_s  = (accept_s && !reqWrite && !err_s)
                        ? load_extract(rd_word_s, size, lane_s, unsignedLoad)
                        : 32'h0000_0000;

  data_mem_resp_pipe #(
    .STAGES (READ_LATENCY)
  ) u_resp_pipe (
    .clk     (clk),
    .rst     (reset),
    .valid_i (resp_valid_s),
    .err_i   (resp_err_s),
    .data_i  (resp_data_s),
    .valid_o (respValid),
    .err_o   (respError),
    .data_o  (dataOut)
  );

  assign reqReady = ready_q;
  assign busy     = busy_q;

endmodule
